// File: rtl/mul_feeder_if.sv
// Operand, randomness, multiplier and result signals of the CLM multiplier front end.
// master is the feeder side; slave is the surrounding system plus multiplier.
interface mul_feeder_if #(
  parameter int unsigned d = 2
) ();
  localparam int unsigned W = 8 + d;
  localparam int unsigned N = 9 + d;

  logic         op_valid;
  logic         op_ready;
  logic [W-1:0] p1_in;
  logic [W-1:0] p2_in;

  logic         rng_valid;
  logic         rng_ready;
  logic [d-1:0] rng_data;

  logic [W-1:0] mul_p1;
  logic [W-1:0] mul_p2;
  logic [d-1:0] mul_random_vect [N];
  logic         mul_drdy_i;
  logic         mul_drdy_o;
  logic [W-1:0] mul_out;

  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] res_data;

  modport master (
    input  op_valid, p1_in, p2_in, rng_valid, rng_data, mul_drdy_o, mul_out, res_ready,
    output op_ready, rng_ready, mul_p1, mul_p2, mul_random_vect, mul_drdy_i, res_valid,
    output res_data
  );

  modport slave (
    output op_valid, p1_in, p2_in, rng_valid, rng_data, mul_drdy_o, mul_out, res_ready,
    input  op_ready, rng_ready, mul_p1, mul_p2, mul_random_vect, mul_drdy_i, res_valid,
    input  res_data
  );
endinterface

// File: rtl/mul_feeder.sv
// Front end of the serial CLM multiplier: latches an operand pair, collects 9+d refresh words,
// launches the multiplier and holds the product. MUL_FEEDER_HIDE_EN masks shares outside launch.
module mul_feeder #(
  parameter int unsigned d = 2
) (
  input  logic         clk,
  input  logic         rst,
  mul_feeder_if.master bus
);
  localparam int unsigned W    = 8 + d;
  localparam int unsigned N    = 9 + d;
  localparam int unsigned CntW = $clog2(N + 1);

  typedef logic [W-1:0] state_t;
  typedef logic [d-1:0] red_poly_t;
  typedef enum logic [1:0] {StIdle, StArmed, StBusy, StDone} fsm_e;

  fsm_e            state_q, state_d;
  logic [CntW-1:0] fill_cnt_q, fill_cnt_d;
  red_poly_t       rnd_q [N];
  red_poly_t       rnd_d [N];
  state_t          p1_q, p1_d;
  state_t          p2_q, p2_d;
  state_t          res_q, res_d;

  logic launch;
  logic buf_full;
  logic rng_accept;

  assign buf_full   = (fill_cnt_q == CntW'(N));
  assign launch     = (state_q == StArmed) && buf_full;
  assign rng_accept = bus.rng_valid && !buf_full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      fill_cnt_q <= '0;
      rnd_q      <= '{default: '0};
      p1_q       <= '0;
      p2_q       <= '0;
      res_q      <= '0;
    end else begin
      state_q    <= state_d;
      fill_cnt_q <= fill_cnt_d;
      rnd_q      <= rnd_d;
      p1_q       <= p1_d;
      p2_q       <= p2_d;
      res_q      <= res_d;
    end
  end

  // Buffer refill runs independently of the FSM; launch always sees a full buffer,
  // so clearing the count there never collides with an accepted word.
  always_comb begin
    fill_cnt_d = fill_cnt_q;
    rnd_d      = rnd_q;
    if (rng_accept) begin
      for (int unsigned i = 0; i < N; i++) begin
        if (fill_cnt_q == CntW'(i)) begin
          rnd_d[i] = bus.rng_data;
        end
      end
      fill_cnt_d = fill_cnt_q + CntW'(1);
    end
    if (launch) begin
      fill_cnt_d = '0;
    end
  end

  always_comb begin
    state_d = state_q;
    p1_d    = p1_q;
    p2_d    = p2_q;
    res_d   = res_q;
    case (state_q)
      StIdle: begin
        if (bus.op_valid) begin
          p1_d    = bus.p1_in;
          p2_d    = bus.p2_in;
          state_d = StArmed;
        end
      end
      StArmed: begin
        if (launch) begin
          state_d = StBusy;
`ifdef MUL_FEEDER_HIDE_EN
          p1_d    = '0;
          p2_d    = '0;
`endif
        end
      end
      // The multiplier restarts at the launch edge, so a leftover done flag is already
      // low by the first busy cycle.
      StBusy: begin
        if (bus.mul_drdy_o) begin
          res_d   = bus.mul_out;
          state_d = StDone;
        end
      end
      StDone: begin
        if (bus.res_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.op_ready   = (state_q == StIdle);
    bus.rng_ready  = !buf_full;
    bus.mul_drdy_i = launch;
    bus.res_valid  = (state_q == StDone);
    bus.res_data   = res_q;
`ifdef MUL_FEEDER_HIDE_EN
    bus.mul_p1 = launch ? p1_q : '0;
    bus.mul_p2 = launch ? p2_q : '0;
    for (int unsigned i = 0; i < N; i++) begin
      bus.mul_random_vect[i] = launch ? rnd_q[i] : '0;
    end
`else
    bus.mul_p1 = p1_q;
    bus.mul_p2 = p2_q;
    for (int unsigned i = 0; i < N; i++) begin
      bus.mul_random_vect[i] = rnd_q[i];
    end
`endif
  end

  launch_single_a: assert property (@(posedge clk) disable iff (rst) launch |=> !launch);
  fill_bound_a: assert property (@(posedge clk) disable iff (rst) fill_cnt_q <= CntW'(N));

endmodule
